// File: rtl/csr_pkg.sv
// csr_pkg: shared op/state encodings, CSR numbers and mstatus bit positions
// for the machine CSR control stage and its address decoder.
package csr_pkg;
   localparam logic [3:0] CAUSE_ECALL = 4'd11;
   typedef enum logic [2:0] {
      OP_RW    = 3'd0,
      OP_RS    = 3'd1,
      OP_RC    = 3'd2,
      OP_ECALL = 3'd3,
      OP_MRET  = 3'd4
   } op_e;
   localparam logic [1:0] MSTATUS = 2'd0;
   localparam logic [1:0] MTVEC   = 2'd1;
   localparam logic [1:0] MEPC    = 2'd2;
   localparam logic [1:0] MCAUSE  = 2'd3;
   localparam logic [11:0] ADDR_MSTATUS = 12'h300;
   localparam logic [11:0] ADDR_MTVEC   = 12'h305;
   localparam logic [11:0] ADDR_MEPC    = 12'h341;
   localparam logic [11:0] ADDR_MCAUSE  = 12'h342;
   localparam int MIE    = 3;
   localparam int MPIE   = 7;
   localparam int MPP_LO = 11;
   localparam int MPP_HI = 12;
   typedef enum logic [2:0] {
      S_IDLE,
      S_EXEC,
      S_TRAP_CAUSE,
      S_TRAP_STATUS,
      S_MRET_EPC,
      S_MRET_STATUS,
      S_ILLEGAL,
      S_RESP
   } state_e;
endpackage

// File: rtl/csr_addr_decode.sv
// csr_addr_decode: maps a 12-bit CSR number onto the 4-entry register file index with an illegal flag
module csr_addr_decode
   import csr_pkg::*;
(
   input  logic [11:0] addr,
   output logic [1:0]  idx,
   output logic        illegal
);
   always_comb begin
      idx     = addr == ADDR_MTVEC  ? MTVEC  :
                addr == ADDR_MEPC   ? MEPC   :
                addr == ADDR_MCAUSE ? MCAUSE : MSTATUS;
      illegal = !(addr == ADDR_MSTATUS || addr == ADDR_MTVEC ||
                  addr == ADDR_MEPC    || addr == ADDR_MCAUSE);
   end
endmodule

// File: rtl/csr_ctrl.sv
// csr_ctrl: sequences CSR read-modify-writes, ECALL traps and MRET against the
// machine CSR register file, one request at a time, with a held response.
module csr_ctrl
   import csr_pkg::*;
#(
   parameter int         XLEN        = 64,
   parameter logic [3:0] CAUSE_ECALL = csr_pkg::CAUSE_ECALL
) (
   input  logic            clock,
   input  logic            reset,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [2:0]      in_op,
   input  logic [11:0]     in_csr_addr,
   input  logic [XLEN-1:0] in_src,
   input  logic [XLEN-1:0] in_pc,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] out_rdata,
   output logic            out_redirect,
   output logic [XLEN-1:0] out_target,
   output logic            out_illegal,
   output logic [2:0]      csr_raddr,
   input  logic [XLEN-1:0] csr_rdata,
   output logic [2:0]      csr_waddr,
   output logic            csr_wen,
   output logic [XLEN-1:0] csr_wdata,
   output logic            csr_exception,
   output logic [XLEN-1:0] csr_epc,
   output logic [3:0]      csr_no
);
   state_e            state_q, state_d;
   op_e               op_q, op_d;
   logic [1:0]        idx_q, idx_d;
   logic [XLEN-1:0]   src_q, src_d;
   logic [XLEN-1:0]   pc_q, pc_d;
   logic [XLEN-1:0]   rdata_q, rdata_d;
   logic [XLEN-1:0]   target_q, target_d;
   logic              redirect_q, redirect_d;
   logic              illegal_q, illegal_d;
   logic [1:0]        dec_idx;
   logic              dec_illegal;
   logic              bad_req;

   csr_addr_decode u_dec (
      .addr    (in_csr_addr),
      .idx     (dec_idx),
      .illegal (dec_illegal)
   );

   // ECALL/MRET ignore the address; only CSR ops can fault on it
   assign bad_req = in_op > 3'd4 || (in_op < 3'd3 && dec_illegal);

   always_comb begin
      state_d       = state_q;
      op_d          = op_q;
      idx_d         = idx_q;
      src_d         = src_q;
      pc_d          = pc_q;
      rdata_d       = rdata_q;
      target_d      = target_q;
      redirect_d    = redirect_q;
      illegal_d     = illegal_q;
      in_ready      = state_q == S_IDLE;
      out_valid     = 1'b0;
      out_rdata     = '0;
      out_redirect  = 1'b0;
      out_target    = '0;
      out_illegal   = 1'b0;
      csr_raddr     = '0;
      csr_waddr     = '0;
      csr_wen       = 1'b0;
      csr_wdata     = '0;
      csr_exception = 1'b0;
      csr_epc       = '0;
      csr_no        = '0;
      case (state_q)
         S_IDLE: if (in_valid) begin
            op_d       = op_e'(in_op);
            idx_d      = dec_idx;
            src_d      = in_src;
            pc_d       = in_pc;
            rdata_d    = '0;
            target_d   = '0;
            redirect_d = 1'b0;
            illegal_d  = bad_req;
            state_d    = bad_req            ? S_ILLEGAL    :
                         in_op == OP_ECALL  ? S_TRAP_CAUSE :
                         in_op == OP_MRET   ? S_MRET_EPC   : S_EXEC;
         end
         S_EXEC: begin
            csr_raddr = {1'b0, idx_q};
            rdata_d   = csr_rdata;
            csr_wen   = 1'b1;
            csr_waddr = {1'b0, idx_q};
            csr_wdata = op_q == OP_RW ? src_q :
                        op_q == OP_RS ? csr_rdata | src_q : csr_rdata & ~src_q;
            state_d   = S_RESP;
         end
         S_TRAP_CAUSE: begin
            csr_exception = 1'b1;
            csr_epc       = pc_q;
            csr_no        = CAUSE_ECALL;
            csr_raddr     = {1'b0, MTVEC};
            target_d      = csr_rdata;
            state_d       = S_TRAP_STATUS;
         end
         S_TRAP_STATUS: begin
            csr_raddr                = {1'b0, MSTATUS};
            csr_wen                  = 1'b1;
            csr_waddr                = {1'b0, MSTATUS};
            csr_wdata                = csr_rdata;
            csr_wdata[MPIE]          = csr_rdata[MIE];
            csr_wdata[MIE]           = 1'b0;
            csr_wdata[MPP_HI:MPP_LO] = 2'b11;
            redirect_d               = 1'b1;
            state_d                  = S_RESP;
         end
         S_MRET_EPC: begin
            csr_raddr = {1'b0, MEPC};
            target_d  = csr_rdata;
            state_d   = S_MRET_STATUS;
         end
         S_MRET_STATUS: begin
            csr_raddr                = {1'b0, MSTATUS};
            csr_wen                  = 1'b1;
            csr_waddr                = {1'b0, MSTATUS};
            csr_wdata                = csr_rdata;
            csr_wdata[MIE]           = csr_rdata[MPIE];
            csr_wdata[MPIE]          = 1'b1;
            csr_wdata[MPP_HI:MPP_LO] = 2'b11;
            redirect_d               = 1'b1;
            state_d                  = S_RESP;
         end
         S_ILLEGAL: state_d = S_RESP;
         S_RESP: begin
            out_valid    = 1'b1;
            out_rdata    = rdata_q;
            out_redirect = redirect_q;
            out_target   = target_q;
            out_illegal  = illegal_q;
            state_d      = out_ready ? S_IDLE : S_RESP;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q    <= S_IDLE;
         op_q       <= OP_RW;
         idx_q      <= '0;
         src_q      <= '0;
         pc_q       <= '0;
         rdata_q    <= '0;
         target_q   <= '0;
         redirect_q <= 1'b0;
         illegal_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         op_q       <= op_d;
         idx_q      <= idx_d;
         src_q      <= src_d;
         pc_q       <= pc_d;
         rdata_q    <= rdata_d;
         target_q   <= target_d;
         redirect_q <= redirect_d;
         illegal_q  <= illegal_d;
      end
   end
endmodule

// File: tb/tb_csr_ctrl.sv
// tb_csr_ctrl: directed CSR/trap vectors against a behavioural register file,
// with expected writes, trap pulses and responses checked by a scoreboard.
module tb_csr_ctrl;
   localparam int XLEN = 64;

   typedef struct {
      logic [XLEN-1:0] rdata;
      logic            redirect;
      logic [XLEN-1:0] target;
      logic            illegal;
   } resp_t;
   typedef struct {
      logic [1:0]      idx;
      logic [XLEN-1:0] data;
   } wr_t;
   typedef struct {
      logic [XLEN-1:0] epc;
      logic [3:0]      no;
   } exc_t;

   logic            clock = 1'b0;
   logic            reset = 1'b0;
   logic            in_valid = 1'b0;
   logic            in_ready;
   logic [2:0]      in_op = '0;
   logic [11:0]     in_csr_addr = '0;
   logic [XLEN-1:0] in_src = '0;
   logic [XLEN-1:0] in_pc = '0;
   logic            out_valid;
   logic            out_ready = 1'b1;
   logic [XLEN-1:0] out_rdata;
   logic            out_redirect;
   logic [XLEN-1:0] out_target;
   logic            out_illegal;
   logic [2:0]      csr_raddr;
   logic [XLEN-1:0] csr_rdata;
   logic [2:0]      csr_waddr;
   logic            csr_wen;
   logic [XLEN-1:0] csr_wdata;
   logic            csr_exception;
   logic [XLEN-1:0] csr_epc;
   logic [3:0]      csr_no;

   logic [XLEN-1:0] rf [4];
   logic            rf_clr = 1'b1;
   resp_t           rq[$];
   wr_t             wq[$];
   exc_t            eq[$];
   int              applied = 0;
   int              errs = 0;

   csr_ctrl #(.XLEN(XLEN), .CAUSE_ECALL(4'd11)) dut (
      .clock(clock), .reset(reset),
      .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
      .in_csr_addr(in_csr_addr), .in_src(in_src), .in_pc(in_pc),
      .out_valid(out_valid), .out_ready(out_ready), .out_rdata(out_rdata),
      .out_redirect(out_redirect), .out_target(out_target), .out_illegal(out_illegal),
      .csr_raddr(csr_raddr), .csr_rdata(csr_rdata), .csr_waddr(csr_waddr),
      .csr_wen(csr_wen), .csr_wdata(csr_wdata), .csr_exception(csr_exception),
      .csr_epc(csr_epc), .csr_no(csr_no)
   );

   always #5 clock = ~clock;

   assign csr_rdata = rf[csr_raddr[1:0]];

   always @(posedge clock) begin
      if (rf_clr) begin
         for (int i = 0; i < 4; i++) rf[i] <= '0;
      end else begin
         if (csr_wen) rf[csr_waddr[1:0]] <= csr_wdata;
         if (csr_exception) begin
            rf[2] <= csr_epc;
            rf[3] <= {{(XLEN-4){1'b0}}, csr_no};
         end
      end
   end

   task automatic chk(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
      applied++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   resp_t r_m;
   wr_t   w_m;
   exc_t  e_m;
   always @(negedge clock) begin
      if (reset) begin
         if (csr_wen && csr_exception) chk("wen_and_exception", 64'(1), 64'(0));
         if (csr_wen) begin
            if (wq.size() == 0) chk("unexpected_write", 64'(csr_waddr), 64'hffff);
            else begin
               w_m = wq.pop_front();
               chk("waddr", 64'(csr_waddr), 64'(w_m.idx));
               chk("wdata", csr_wdata, w_m.data);
            end
         end
         if (csr_exception) begin
            if (eq.size() == 0) chk("unexpected_exception", csr_epc, 64'hffff);
            else begin
               e_m = eq.pop_front();
               chk("epc", csr_epc, e_m.epc);
               chk("cause_no", 64'(csr_no), 64'(e_m.no));
            end
         end
         if (out_valid && out_ready) begin
            if (rq.size() == 0) chk("unexpected_resp", out_rdata, 64'hffff);
            else begin
               r_m = rq.pop_front();
               chk("out_rdata", out_rdata, r_m.rdata);
               chk("out_redirect", 64'(out_redirect), 64'(r_m.redirect));
               chk("out_target", out_target, r_m.target);
               chk("out_illegal", 64'(out_illegal), 64'(r_m.illegal));
            end
         end
      end
   end

   task automatic drive(input logic [2:0] op, input logic [11:0] a,
                        input logic [XLEN-1:0] s, input logic [XLEN-1:0] p);
      @(negedge clock);
      chk("in_ready_idle", 64'(in_ready), 64'(1));
      in_valid = 1'b1; in_op = op; in_csr_addr = a; in_src = s; in_pc = p;
      @(negedge clock);
      in_valid = 1'b0;
   endtask

   task automatic wait_done();
      int n = 0;
      while (rq.size() != 0 && n < 30) begin
         @(negedge clock);
         n++;
      end
      chk("resp_pending", 64'(rq.size()), 64'(0));
      chk("writes_pending", 64'(wq.size()), 64'(0));
      chk("exc_pending", 64'(eq.size()), 64'(0));
      rq.delete(); wq.delete(); eq.delete();
   endtask

   task automatic csr_op(input logic [2:0] op, input logic [11:0] a, input logic [XLEN-1:0] s,
                         input logic wen, input logic [1:0] widx, input logic [XLEN-1:0] wdata,
                         input logic [XLEN-1:0] old, input logic ill);
      if (wen) wq.push_back('{widx, wdata});
      rq.push_back('{old, 1'b0, '0, ill});
      drive(op, a, s, '0);
      wait_done();
   endtask

   task automatic check_idle_outputs(input string tag);
      chk({tag, "_in_ready"}, 64'(in_ready), 64'(1));
      chk({tag, "_out_valid"}, 64'(out_valid), 64'(0));
      chk({tag, "_wen"}, 64'(csr_wen), 64'(0));
      chk({tag, "_exception"}, 64'(csr_exception), 64'(0));
      chk({tag, "_flags"}, 64'({out_redirect, out_illegal}), 64'(0));
      chk({tag, "_data"}, out_rdata | out_target | csr_wdata | csr_epc, 64'(0));
      chk({tag, "_idx"}, 64'({csr_raddr, csr_waddr, csr_no}), 64'(0));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) @(negedge clock);
      check_idle_outputs("reset");
      rf_clr = 1'b0;
      reset = 1'b1;

      csr_op(3'd0, 12'h305, 64'h80000100, 1'b1, 2'd1, 64'h80000100, 64'h0, 1'b0);
      csr_op(3'd0, 12'h300, 64'ha00001800, 1'b1, 2'd0, 64'ha00001800, 64'h0, 1'b0);
      csr_op(3'd1, 12'h300, 64'h8, 1'b1, 2'd0, 64'ha00001808, 64'ha00001800, 1'b0);

      eq.push_back('{64'h80000040, 4'd11});
      wq.push_back('{2'd0, 64'ha00001880});
      rq.push_back('{64'h0, 1'b1, 64'h80000100, 1'b0});
      drive(3'd3, 12'h000, 64'h0, 64'h80000040);
      wait_done();
      chk("mepc_after_ecall", rf[2], 64'h80000040);
      chk("mcause_after_ecall", rf[3], 64'd11);

      csr_op(3'd0, 12'h341, 64'h80000044, 1'b1, 2'd2, 64'h80000044, 64'h80000040, 1'b0);

      wq.push_back('{2'd0, 64'ha00001888});
      rq.push_back('{64'h0, 1'b1, 64'h80000044, 1'b0});
      drive(3'd4, 12'h000, 64'h0, 64'h0);
      wait_done();

      csr_op(3'd2, 12'h342, 64'hff, 1'b1, 2'd3, 64'h0, 64'd11, 1'b0);

      out_ready = 1'b0;
      rq.push_back('{64'h0, 1'b0, 64'h0, 1'b1});
      drive(3'd2, 12'h7c0, 64'hffff, 64'h0);
      @(negedge clock);
      for (int c = 0; c < 3; c++) begin
         chk("stall_out_valid", 64'(out_valid), 64'(1));
         chk("stall_out_illegal", 64'(out_illegal), 64'(1));
         chk("stall_out_rdata", out_rdata, 64'h0);
         chk("stall_in_ready", 64'(in_ready), 64'(0));
         @(negedge clock);
      end
      out_ready = 1'b1;
      wait_done();

      csr_op(3'd6, 12'h300, 64'h1, 1'b0, 2'd0, 64'h0, 64'h0, 1'b1);

      eq.push_back('{64'h80000080, 4'd11});
      drive(3'd3, 12'h000, 64'h0, 64'h80000080);
      @(posedge clock);
      #1 reset = 1'b0;
      #1 check_idle_outputs("abort");
      repeat (2) @(negedge clock);
      check_idle_outputs("abort_hold");
      chk("abort_mepc", rf[2], 64'h80000080);
      chk("abort_mcause", rf[3], 64'd11);
      chk("abort_mstatus", rf[0], 64'ha00001888);
      chk("abort_exc_seen", 64'(eq.size()), 64'(0));
      reset = 1'b1;
      rq.delete(); wq.delete(); eq.delete();

      csr_op(3'd0, 12'h305, 64'h1234, 1'b1, 2'd1, 64'h1234, 64'h80000100, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", applied, errs);
      $finish;
   end
endmodule
